trng_word_collector: RTL and testbench
======================================

Name: trng_word_collector

Overview:
- Parametrised successor to the single-bit SR-latch entropy network.
- Samples NUM_SOURCES free-running latch outputs and XOR-reduces them to one raw bit per cycle.
- Optionally debiases the stream (von Neumann) and runs a repetition-count health test.
- Packs accepted bits into WORD_WIDTH words and delivers them over a valid/ready handshake to the project's output mux.

Parameters:
- NUM_SOURCES, 8: number of latch outputs on raw_bits (≥1).
- WORD_WIDTH, 8: bits per output word (≥2).
- DEBIAS, 1: 1 enables the von Neumann corrector; 0 passes every sample.
- REP_LIMIT, 16: identical consecutive raw bits that trip health_fail (≥2, ≤255).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  collection enable; low pauses collection.
- raw_bits  input  NUM_SOURCES  asynchronous latch outputs.
- word_out  output  WORD_WIDTH  collected random word.
- word_valid  output  1  word_out holds an unconsumed word.
- word_ready  input  1  consumer accepts the word when valid & ready.
- health_fail  output  1  sticky repetition-test failure flag.
- bit_count  output  $clog2(WORD_WIDTH+1)  bits currently held in the shift register (debug).

Behaviour:
- Reset (clk edge with reset=1): all outputs are 0, all internal state is cleared, synchronizer flops are 0.
- Input path: 2-flop synchronizer on raw_bits, then a sample register holding the XOR reduction. A change on raw_bits reaches sample 3 cycles later. The pipeline runs regardless of enable.
- Sample acceptance:
  - A sample counts as "taken" on each cycle where enable=1, health_fail=0 and the pipeline has been primed. Priming takes 3 cycles after reset deassertion or after enable rises.
  - enable=0 does not flush the shift register.
- Debias FSM (DEBIAS=1), states PAIR_FIRST and PAIR_SECOND:
  - PAIR_FIRST: store the sample, go to PAIR_SECOND.
  - PAIR_SECOND: if the sample differs from the stored bit, emit the stored bit (pair 10 emits 1, pair 01 emits 0); otherwise emit nothing. Return to PAIR_FIRST.
  - enable=0 forces PAIR_FIRST.
  - DEBIAS=0: every taken sample is emitted.
- Packing:
  - An emitted bit shifts into the LSB of the shift register (left shift) and bit_count increments.
  - When bit_count reaches WORD_WIDTH and the output register is free, the shift register is copied to word_out the same cycle. word_valid=1 on the next cycle and bit_count returns to 0.
  - "Free" means word_valid=0, or word_valid=1 with word_ready=1 this cycle.
  - A simultaneous transfer and load keeps word_valid=1 with the new word.
- Backpressure:
  - If the shift register is full and the output register is not free, further emitted bits are discarded.
  - bit_count stays at WORD_WIDTH until the load happens.
- Handshake:
  - word_out is stable while word_valid=1 and word_ready=0.
  - On valid & ready, word_valid drops next cycle unless a new load occurs.
- Health test:
  - rep_cnt (8-bit, saturating) counts consecutive identical taken samples, before debiasing.
  - rep_cnt resets to 1 when the sample changes and to 0 when enable=0.
  - When rep_cnt reaches REP_LIMIT, health_fail=1 next cycle. It stays set until reset.
  - While health_fail=1: word_valid is forced 0, the shift register and bit_count clear, and no samples are taken.
- Reset mid-operation: a partial word and a pending word are both discarded.

Decomposition:
- Shared package trng_pkg: debias state enum, default REP_LIMIT, and the synchronizer depth constant (2).
- One natural sub-module, trng_debias: the von Neumann pair FSM (inputs: sample, take, enable; outputs: bit, bit_valid).
- Synchronizer, XOR reduction, packing and health logic stay in the top module.

Test Plan:
1. DEBIAS=0, enable=1, word_ready=1; drive raw_bits so the XOR sequence is 1,0,1,1,0,0,1,0 on consecutive cycles -> word_out=8'hB2, word_valid high 1 cycle, first valid 3 cycles after the last bit applied.
2. DEBIAS=1; XOR pairs 10,01,00,11,10,10,01,01,10,01 -> 8 emitted bits 1,0,1,1,0,0,1,0 -> word_out=8'hB2; pairs 00/11 emit nothing (bit_count unchanged).
3. Backpressure: DEBIAS=0, word_ready=0; feed 24 alternating-source bits -> first word held stable, bit_count saturates at 8, third word's bits dropped; raise word_ready -> first word, then second word, then valid=0.
4. Health: XOR held at 1 for 16 taken cycles with REP_LIMIT=16 -> health_fail=1, word_valid=0, bit_count=0; toggling input afterwards keeps the fail set; reset clears it.
5. Reset mid-word: 5 bits collected, pulse reset 1 cycle -> bit_count=0, word_valid=0, outputs 0; next full word correct.
6. enable drop: DEBIAS=1, enable low between the two bits of a pair -> pair discarded, rep_cnt=0, bit_count preserved; after re-enable, priming takes 3 cycles before the next taken sample.

Source files
------------

// File: rtl/trng_pkg.sv
// Shared definitions for the TRNG word collector.
//   debias_state_e    : von Neumann pair FSM states
//   REP_LIMIT_DEFAULT : default repetition-count threshold
//   SYNC_DEPTH        : flops in the raw_bits synchronizer
//   PRIME_CYCLES      : cycles before a fresh sample reaches the sample register
package trng_pkg;
    typedef enum logic {
        PAIR_FIRST  = 1'b0,
        PAIR_SECOND = 1'b1
    } debias_state_e;

    localparam int REP_LIMIT_DEFAULT = 16;
    localparam int SYNC_DEPTH        = 2;
    // synchronizer depth plus the XOR sample register
    localparam int PRIME_CYCLES      = SYNC_DEPTH + 1;
endpackage

// File: rtl/trng_debias.sv
// Von Neumann corrector: consumes taken samples in pairs and emits the first
// bit of each unequal pair (10 -> 1, 01 -> 0). Equal pairs emit nothing.
//   clk, reset : clock, synchronous active-high reset
//   sample     : current raw sample
//   take       : sample is consumed this cycle
//   enable     : collection enable; low abandons a half-finished pair
//   vn_bit     : corrected output bit
//   bit_valid  : vn_bit is emitted this cycle
module trng_debias
    import trng_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic sample,
    input  logic take,
    input  logic enable,
    output logic vn_bit,
    output logic bit_valid
);
    debias_state_e state, state_next;
    logic          first_bit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= PAIR_FIRST;
            first_bit <= 1'b0;
        end else begin
            state <= state_next;
            if (take && state == PAIR_FIRST)
                first_bit <= sample;
        end
    end

    always_comb begin
        state_next = state;
        if (!enable)
            state_next = PAIR_FIRST;
        else if (take)
            state_next = (state == PAIR_FIRST) ? PAIR_SECOND : PAIR_FIRST;
    end

    always_comb begin
        vn_bit    = first_bit;
        bit_valid = take && (state == PAIR_SECOND) && (sample != first_bit);
    end
endmodule

// File: rtl/trng_word_collector.sv
// Samples NUM_SOURCES free-running latch outputs, XOR-reduces them to one raw
// bit per cycle, optionally debiases, runs a repetition-count health test and
// packs accepted bits into WORD_WIDTH words behind a valid/ready handshake.
//   clk, reset  : clock, synchronous active-high reset
//   enable      : collection enable (pipeline keeps running when low)
//   raw_bits    : asynchronous latch outputs
//   word_out    : collected word, stable while word_valid && !word_ready
//   word_valid  : word_out holds an unconsumed word
//   word_ready  : consumer accepts on word_valid && word_ready
//   health_fail : sticky repetition-test failure
//   bit_count   : bits currently held in the shift register
module trng_word_collector
    import trng_pkg::*;
#(
    parameter int NUM_SOURCES = 8,
    parameter int WORD_WIDTH  = 8,
    parameter int DEBIAS      = 1,
    parameter int REP_LIMIT   = REP_LIMIT_DEFAULT
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              enable,
    input  logic [NUM_SOURCES-1:0]            raw_bits,
    output logic [WORD_WIDTH-1:0]             word_out,
    output logic                              word_valid,
    input  logic                              word_ready,
    output logic                              health_fail,
    output logic [$clog2(WORD_WIDTH+1)-1:0]   bit_count
);
    localparam int               CNT_W      = $clog2(WORD_WIDTH + 1);
    localparam logic [CNT_W-1:0] FULL       = CNT_W'(WORD_WIDTH);
    localparam logic [7:0]       REP_MAX    = 8'(REP_LIMIT);
    localparam logic [1:0]       PRIME_DONE = 2'(PRIME_CYCLES);

    // ---------------- input path: synchronizer + XOR sample ----------------
    logic [SYNC_DEPTH-1:0][NUM_SOURCES-1:0] sync_q;
    logic                                   sample;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            sample <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], raw_bits};
            sample <= ^sync_q[SYNC_DEPTH-1];
        end
    end

    // ---------------- priming / sample acceptance ----------------
    // After reset or an enable rise the sample register still holds data
    // from before collection started; wait until fresh data has arrived.
    logic [1:0] prime_cnt;
    logic       take;

    always_ff @(posedge clk) begin
        if (reset || !enable)
            prime_cnt <= 2'd0;
        else if (prime_cnt != PRIME_DONE)
            prime_cnt <= prime_cnt + 2'd1;
    end

    assign take = enable && !health_fail && (prime_cnt == PRIME_DONE);

    // ---------------- debias ----------------
    logic emit, emit_bit;

    generate
        if (DEBIAS != 0) begin : g_vn
            trng_debias u_debias (
                .clk       (clk),
                .reset     (reset),
                .sample    (sample),
                .take      (take),
                .enable    (enable),
                .vn_bit    (emit_bit),
                .bit_valid (emit)
            );
        end else begin : g_pass
            assign emit     = take;
            assign emit_bit = sample;
        end
    endgenerate

    // ---------------- health test (on raw samples, before debias) ----------------
    logic [7:0] rep_cnt;
    logic       last_sample;

    always_ff @(posedge clk) begin
        if (reset) begin
            rep_cnt     <= 8'd0;
            last_sample <= 1'b0;
            health_fail <= 1'b0;
        end else begin
            if (rep_cnt >= REP_MAX)
                health_fail <= 1'b1;
            if (!enable) begin
                rep_cnt <= 8'd0;
            end else if (take) begin
                last_sample <= sample;
                // rep_cnt==0 means no previous sample in this run
                if (rep_cnt != 8'd0 && sample == last_sample) begin
                    if (rep_cnt != 8'hFF)
                        rep_cnt <= rep_cnt + 8'd1;
                end else begin
                    rep_cnt <= 8'd1;
                end
            end
        end
    end

    // ---------------- packing and output handshake ----------------
    logic [WORD_WIDTH-1:0] shift_reg;
    logic                  full, free, load;

    assign full = (bit_count == FULL);
    assign free = !word_valid || word_ready;
    assign load = full && free && !health_fail;

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg  <= '0;
            bit_count  <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
        end else if (health_fail) begin
            shift_reg  <= '0;
            bit_count  <= '0;
            word_valid <= 1'b0;
        end else begin
            if (load) begin
                word_out   <= shift_reg;
                word_valid <= 1'b1;
            end else if (word_valid && word_ready) begin
                word_valid <= 1'b0;
            end

            // A bit emitted on the load cycle starts the next word rather
            // than being lost; a bit arriving while full and blocked is dropped.
            if (load) begin
                shift_reg <= {{(WORD_WIDTH-1){1'b0}}, emit & emit_bit};
                bit_count <= {{(CNT_W-1){1'b0}}, emit};
            end else if (emit && !full) begin
                shift_reg <= {shift_reg[WORD_WIDTH-2:0], emit_bit};
                bit_count <= bit_count + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_trng_word_collector.sv
// Bench for trng_word_collector: two instances (DEBIAS=0 and DEBIAS=1) share
// one stimulus stream; a cycle-level reference model built from the stream
// rules (delay line, pair buffer, run length, bit accumulator) is compared
// against both every cycle, plus directed word checks per scenario.
module tb_trng_word_collector;
    localparam int NS  = 8;
    localparam int WW  = 8;
    localparam int LIM = 16;

    logic                 clk = 1'b0;
    logic                 reset, enable, word_ready;
    logic [NS-1:0]        raw_bits;
    logic [1:0][WW-1:0]   word_out;
    logic [1:0]           word_valid, health_fail;
    logic [1:0][3:0]      bit_count;

    always #5 clk = ~clk;

    trng_word_collector #(.NUM_SOURCES(NS), .WORD_WIDTH(WW), .DEBIAS(0), .REP_LIMIT(LIM)) dut0 (
        .clk(clk), .reset(reset), .enable(enable), .raw_bits(raw_bits),
        .word_out(word_out[0]), .word_valid(word_valid[0]), .word_ready(word_ready),
        .health_fail(health_fail[0]), .bit_count(bit_count[0]));

    trng_word_collector #(.NUM_SOURCES(NS), .WORD_WIDTH(WW), .DEBIAS(1), .REP_LIMIT(LIM)) dut1 (
        .clk(clk), .reset(reset), .enable(enable), .raw_bits(raw_bits),
        .word_out(word_out[1]), .word_valid(word_valid[1]), .word_ready(word_ready),
        .health_fail(health_fail[1]), .bit_count(bit_count[1]));

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int delay_q[$];          // XOR values still travelling toward the sample point
    int m_sample = 0;        // value at the sample point
    int en_run   = 0;        // consecutive enabled cycles since reset / enable rise
    int pend     = -1;       // first bit of an open pair (instance 1), -1 = none
    int run      = 0, last = 0, m_fail = 0;
    int acc[2]     = '{0, 0};
    int cnt[2]     = '{0, 0};
    int m_valid[2] = '{0, 0};
    int m_word[2]  = '{0, 0};
    logic [7:0] seen0[$], seen1[$];   // words the DUTs handed over

    task automatic model_step();
        int take, e, b, ld;
        if (reset) begin
            delay_q.delete(); delay_q.push_back(0); delay_q.push_back(0);
            m_sample = 0; en_run = 0; pend = -1; run = 0; last = 0; m_fail = 0;
            for (int i = 0; i < 2; i++) begin
                acc[i] = 0; cnt[i] = 0; m_valid[i] = 0; m_word[i] = 0;
            end
            return;
        end
        take = (enable && !m_fail && en_run >= 3) ? 1 : 0;
        for (int i = 0; i < 2; i++) begin
            e = 0; b = 0;
            if (i == 0) begin
                e = take; b = m_sample;
            end else if (!enable) begin
                pend = -1;
            end else if (take) begin
                if (pend < 0) pend = m_sample;
                else begin
                    if (m_sample != pend) begin e = 1; b = pend; end
                    pend = -1;
                end
            end
            if (m_fail) begin
                acc[i] = 0; cnt[i] = 0; m_valid[i] = 0;
            end else begin
                ld = (cnt[i] == WW && (!m_valid[i] || word_ready)) ? 1 : 0;
                if (ld) begin m_word[i] = acc[i]; m_valid[i] = 1; end
                else if (m_valid[i] && word_ready) m_valid[i] = 0;
                if (ld) begin acc[i] = e ? b : 0; cnt[i] = e; end
                else if (e && cnt[i] < WW) begin
                    acc[i] = ((acc[i] << 1) | b) & ((1 << WW) - 1);
                    cnt[i]++;
                end
            end
        end
        if (run >= LIM) m_fail = 1;
        if (!enable) run = 0;
        else if (take) begin
            run  = (run != 0 && m_sample == last) ? ((run < 255) ? run + 1 : 255) : 1;
            last = m_sample;
        end
        en_run   = enable ? ((en_run < 3) ? en_run + 1 : 3) : 0;
        m_sample = delay_q.pop_front();
        delay_q.push_back(int'(^raw_bits));
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("valid%0d", i),  word_valid[i],  m_valid[i][0]);
            chk($sformatf("bitcnt%0d", i), bit_count[i],   cnt[i][3:0]);
            chk($sformatf("hfail%0d", i),  health_fail[i], m_fail[0]);
            chk($sformatf("word%0d", i),   word_out[i],    m_word[i][WW-1:0]);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    int fill_last = 0, fill_run = 0;

    // random bit that never extends a run past 9
    function automatic logic fill_bit();
        logic bv;
        bv = 1'($urandom);
        if (fill_run >= 9 && int'(bv) == fill_last) bv = ~bv;
        if (int'(bv) == fill_last) fill_run++; else fill_run = 1;
        fill_last = int'(bv);
        return bv;
    endfunction

    function automatic logic [NS-1:0] raw_with(input logic x);
        logic [NS-1:0] r;
        r    = NS'($urandom);
        r[0] = 1'b0;
        r[0] = (^r) ^ x;
        return r;
    endfunction

    task automatic step(input logic r, input logic en, input logic rdy, input logic x);
        reset = r; enable = en; word_ready = rdy; raw_bits = raw_with(x);
        if (!r && rdy && word_valid[0]) seen0.push_back(word_out[0]);
        if (!r && rdy && word_valid[1]) seen1.push_back(word_out[1]);
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        seen0.delete(); seen1.delete();
    endtask

    initial begin
        logic [7:0]  pat8, w1, w2;
        logic [19:0] pat20;
        logic        bits[24];

        reset = 1'b1; enable = 1'b0; word_ready = 1'b0; raw_bits = '0;
        @(negedge clk);
        do_reset();
        chk("rst_valid0", word_valid[0], 1'b0);
        chk("rst_word1",  word_out[1],   8'h00);

        // 1: straight packing, DEBIAS=0
        pat8 = 8'hB2;
        for (int k = 7; k >= 0; k--) step(1'b0, 1'b1, 1'b1, pat8[k]);
        repeat (12) step(1'b0, 1'b1, 1'b1, fill_bit());
        chk("t1_nwords", seen0.size() > 0, 1'b1);
        if (seen0.size() > 0) chk("t1_word", seen0[0], 8'hB2);

        // 2: von Neumann pairs 10,01,00,11,10,10,01,01,10,01
        do_reset();
        pat20 = 20'h93A59;
        for (int k = 19; k >= 0; k--) step(1'b0, 1'b1, 1'b1, pat20[k]);
        repeat (12) step(1'b0, 1'b1, 1'b1, fill_bit());
        chk("t2_nwords", seen1.size() > 0, 1'b1);
        if (seen1.size() > 0) chk("t2_word", seen1[0], 8'hB2);

        // 3: backpressure
        do_reset();
        w1 = '0; w2 = '0;
        for (int k = 0; k < 24; k++) begin
            bits[k] = fill_bit();
            if (k < 8) w1 = {w1[6:0], bits[k]};
            else if (k < 16) w2 = {w2[6:0], bits[k]};
            step(1'b0, 1'b1, 1'b0, bits[k]);
        end
        repeat (3) step(1'b0, 1'b1, 1'b0, fill_bit());
        chk("t3_cnt_sat", bit_count[0],  4'd8);
        chk("t3_valid",   word_valid[0], 1'b1);
        chk("t3_hold",    word_out[0],   w1);
        repeat (2) step(1'b0, 1'b0, 1'b0, fill_bit());
        chk("t3_stable",  word_out[0],   w1);
        repeat (6) step(1'b0, 1'b0, 1'b1, fill_bit());
        chk("t3_nwords",  seen0.size(),  32'd2);
        if (seen0.size() == 2) begin
            chk("t3_first",  seen0[0], w1);
            chk("t3_second", seen0[1], w2);
        end
        chk("t3_drained", word_valid[0], 1'b0);

        // 4: repetition health test
        do_reset();
        repeat (25) step(1'b0, 1'b1, 1'b1, 1'b1);
        chk("t4_fail0",  health_fail[0], 1'b1);
        chk("t4_fail1",  health_fail[1], 1'b1);
        chk("t4_valid",  word_valid[0],  1'b0);
        chk("t4_cnt",    bit_count[0],   4'd0);
        for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 1'b1, 1'(k));
        chk("t4_sticky", health_fail[0], 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("t4_clear",  health_fail[0], 1'b0);

        // 5: reset mid-word
        do_reset();
        repeat (8) step(1'b0, 1'b1, 1'b1, fill_bit());
        chk("t5_partial", bit_count[0], 4'd5);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("t5_cnt",  bit_count[0], 4'd0);
        chk("t5_word", word_out[0],  8'h00);
        seen0.delete();
        w1 = '0;
        for (int k = 0; k < 8; k++) begin
            bits[k] = fill_bit();
            w1 = {w1[6:0], bits[k]};
            step(1'b0, 1'b1, 1'b1, bits[k]);
        end
        repeat (8) step(1'b0, 1'b1, 1'b1, fill_bit());
        chk("t5_nwords", seen0.size() > 0, 1'b1);
        if (seen0.size() > 0) chk("t5_after", seen0[0], w1);

        // 6: enable dropped mid-pair, DEBIAS=1
        do_reset();
        pat8 = 8'b10011000;   // samples 1,0,0,1,1 then filler
        for (int k = 7; k >= 0; k--) step(1'b0, 1'b1, 1'b1, pat8[k]);
        chk("t6_before", bit_count[1], 4'd2);
        repeat (3) step(1'b0, 1'b0, 1'b1, fill_bit());
        chk("t6_kept", bit_count[1], 4'd2);
        repeat (20) step(1'b0, 1'b1, 1'b1, fill_bit());

        // randomized traffic
        for (int k = 0; k < 800; k++)
            step(($urandom % 250) == 0, ($urandom % 25) != 0,
                 ($urandom % 4) != 0, fill_bit());

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
